// File: rtl/i2c_pkg.sv
// Shared I2C definitions: bus field widths and the target FSM state encoding.
package i2c_pkg;

  localparam int ADDR_W = 7;
  localparam int BYTE_W = 8;

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_ADDR      = 4'd1,
    ST_ADDR_ACK  = 4'd2,
    ST_RX_DATA   = 4'd3,
    ST_RX_ACK    = 4'd4,
    ST_TX_DATA   = 4'd5,
    ST_TX_ACK    = 4'd6,
    ST_WAIT_STOP = 4'd7
  } i2c_state_e;

endpackage

// File: rtl/i2c_sync_edge.sv
// Two-flop synchronizer for one bus line, plus a third stage for edge detection.
module i2c_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic pin,
  output logic level,
  output logic prev,
  output logic rise,
  output logic fall
);

  logic pin_p0, pin_p1, pin_p2;

  // Idle bus lines are pulled high, so every stage resets to 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pin_p0 <= 1'b1;
      pin_p1 <= 1'b1;
      pin_p2 <= 1'b1;
    end else begin
      pin_p0 <= pin;
      pin_p1 <= pin_p0;
      pin_p2 <= pin_p1;
    end
  end

  assign level = pin_p1;
  assign prev  = pin_p2;
  assign rise  = pin_p1 & ~pin_p2;
  assign fall  = ~pin_p1 & pin_p2;

endmodule

// File: rtl/i2c_subordinate.sv
// I2C target: 7-bit address match, write-byte capture and read-byte shifting on SDA.
module i2c_subordinate
  import i2c_pkg::*;
#(
  parameter logic [ADDR_W-1:0] OWN_ADDR = 7'h01
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              scl_in,
  input  logic              sda_in,
  output logic              sda_oe,
  input  logic [BYTE_W-1:0] tx_data,
  output logic              tx_load,
  output logic [BYTE_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              busy,
  output logic              rw_flag,
  output logic [3:0]        state_out
);

  logic scl_lvl, scl_prev, scl_rise, scl_fall;
  logic sda_lvl, sda_unused, sda_rise, sda_fall;
  logic start_det, stop_det;

  i2c_sync_edge u_scl_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .pin   (scl_in),
    .level (scl_lvl),
    .prev  (scl_prev),
    .rise  (scl_rise),
    .fall  (scl_fall)
  );

  i2c_sync_edge u_sda_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .pin   (sda_in),
    .level (sda_lvl),
    .prev  (sda_unused),
    .rise  (sda_rise),
    .fall  (sda_fall)
  );

  // SCL must be high in both samples, so an SDA edge coincident with an SCL edge is ignored.
  assign start_det = sda_fall & scl_lvl & scl_prev;
  assign stop_det  = sda_rise & scl_lvl & scl_prev;

  i2c_state_e        state, state_n;
  logic [2:0]        bit_cnt, bit_cnt_n;
  logic [BYTE_W-1:0] shift, shift_n, shift_in;
  logic [BYTE_W-1:0] tx_shift, tx_shift_n;
  logic [BYTE_W-1:0] rx_data_n;
  logic              rx_valid_n, tx_load_n, busy_n, rw_flag_n, sda_oe_n;
  logic              pend, pend_n;

  assign shift_in = {shift[BYTE_W-2:0], sda_lvl};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      bit_cnt  <= 3'd7;
      shift    <= '0;
      tx_shift <= '0;
      rx_data  <= '0;
      rx_valid <= 1'b0;
      tx_load  <= 1'b0;
      busy     <= 1'b0;
      rw_flag  <= 1'b0;
      sda_oe   <= 1'b0;
      pend     <= 1'b0;
    end else begin
      state    <= state_n;
      bit_cnt  <= bit_cnt_n;
      shift    <= shift_n;
      tx_shift <= tx_shift_n;
      rx_data  <= rx_data_n;
      rx_valid <= rx_valid_n;
      tx_load  <= tx_load_n;
      busy     <= busy_n;
      rw_flag  <= rw_flag_n;
      sda_oe   <= sda_oe_n;
      pend     <= pend_n;
    end
  end

  // pend marks a completed byte (ADDR/RX_DATA) or an ACKed, reloaded byte (TX_ACK)
  // waiting for the next SCL fall, since SDA may only change while SCL is low.
  always_comb begin
    state_n    = state;
    bit_cnt_n  = bit_cnt;
    shift_n    = shift;
    tx_shift_n = tx_shift;
    rx_data_n  = rx_data;
    rx_valid_n = 1'b0;
    tx_load_n  = 1'b0;
    busy_n     = busy;
    rw_flag_n  = rw_flag;
    sda_oe_n   = sda_oe;
    pend_n     = pend;

    if (stop_det) begin
      state_n  = ST_IDLE;
      bit_cnt_n = 3'd7;
      sda_oe_n = 1'b0;
      busy_n   = 1'b0;
      pend_n   = 1'b0;
    end else if (start_det) begin
      state_n   = ST_ADDR;
      bit_cnt_n = 3'd7;
      sda_oe_n  = 1'b0;
      pend_n    = 1'b0;
    end else begin
      case (state)
        ST_ADDR, ST_RX_DATA: begin
          if (scl_rise) begin
            shift_n   = shift_in;
            bit_cnt_n = bit_cnt - 3'd1;
            if (bit_cnt == 3'd0) begin
              pend_n = 1'b1;
              if (state == ST_RX_DATA) begin
                rx_data_n  = shift_in;
                rx_valid_n = 1'b1;
              end
            end
          end else if (scl_fall && pend) begin
            pend_n = 1'b0;
            if (state == ST_RX_DATA) begin
              state_n  = ST_RX_ACK;
              sda_oe_n = 1'b1;
            end else if (shift[BYTE_W-1:1] == OWN_ADDR) begin
              state_n   = ST_ADDR_ACK;
              sda_oe_n  = 1'b1;
              rw_flag_n = shift[0];
              busy_n    = 1'b1;
            end else begin
              state_n  = ST_WAIT_STOP;
              sda_oe_n = 1'b0;
              busy_n   = 1'b0;
            end
          end
        end

        ST_ADDR_ACK: begin
          if (scl_fall) begin
            bit_cnt_n = 3'd7;
            if (rw_flag) begin
              state_n    = ST_TX_DATA;
              tx_shift_n = tx_data;
              tx_load_n  = 1'b1;
              sda_oe_n   = ~tx_data[BYTE_W-1];
            end else begin
              state_n  = ST_RX_DATA;
              sda_oe_n = 1'b0;
            end
          end
        end

        ST_RX_ACK: begin
          if (scl_fall) begin
            state_n  = ST_RX_DATA;
            sda_oe_n = 1'b0;
          end
        end

        ST_TX_DATA: begin
          if (scl_fall) begin
            if (bit_cnt == 3'd0) begin
              state_n   = ST_TX_ACK;
              bit_cnt_n = 3'd7;
              sda_oe_n  = 1'b0;
            end else begin
              bit_cnt_n = bit_cnt - 3'd1;
              sda_oe_n  = ~tx_shift[bit_cnt_n];
            end
          end
        end

        ST_TX_ACK: begin
          if (scl_rise) begin
            if (!sda_lvl) begin
              tx_shift_n = tx_data;
              tx_load_n  = 1'b1;
              pend_n     = 1'b1;
            end else begin
              state_n  = ST_WAIT_STOP;
              sda_oe_n = 1'b0;
            end
          end else if (scl_fall && pend) begin
            pend_n    = 1'b0;
            state_n   = ST_TX_DATA;
            bit_cnt_n = 3'd7;
            sda_oe_n  = ~tx_shift[BYTE_W-1];
          end
        end

        default: ;
      endcase
    end
  end

  assign state_out = state;

endmodule

// File: doc/i2c_subordinate.md
I2C_SUBORDINATE -- requirements
Module: i2c_subordinate

Interface
REQ-001 Parameter OWN_ADDR, default 7'h01: 7-bit address this subordinate acknowledges.
REQ-002 clk  input  1  system clock; frequency at least 8x SCL frequency.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 scl_in  input  1  raw bus SCL, asynchronous to clk.
REQ-005 sda_in  input  1  raw bus SDA, asynchronous to clk.
REQ-006 sda_oe  output  1  1 = pull SDA low (open-drain); 0 = release.
REQ-007 tx_data  input  8  byte returned on the next read byte; sampled at load time.
REQ-008 tx_load  output  1  one-clk pulse when tx_data is captured into the shift register.
REQ-009 rx_data  output  8  last byte written by the master.
REQ-010 rx_valid  output  1  one-clk pulse when rx_data updates.
REQ-011 busy  output  1  high from address match until STOP or NACK-to-idle.
REQ-012 rw_flag  output  1  R/W bit of the current addressed transaction.
REQ-013 state_out  output  4  current FSM state encoding, for debug.

Function
REQ-014 scl_in and sda_in SHALL pass 2-flop synchronizers; edges are detected on the synchronized values, so pin events act 3 clks later.
REQ-015 START = synchronized SDA falls while synchronized SCL is high in both samples; STOP = SDA rises under the same condition.
REQ-016 START in any state SHALL go to ADDR with bit counter 7 (repeated start supported); STOP in any state SHALL go to IDLE and release sda_oe.
REQ-017 States/encoding: IDLE=0, ADDR=1, ADDR_ACK=2, RX_DATA=3, RX_ACK=4, TX_DATA=5, TX_ACK=6, WAIT_STOP=7.
REQ-018 Shift-in on SCL rising edge, MSB first; outputs change only on SCL falling edge.
REQ-019 ADDR: after 8 bits, match on [7:1]==OWN_ADDR -> ADDR_ACK at next SCL fall with sda_oe=1, rw_flag=bit0, busy=1; mismatch -> WAIT_STOP, sda_oe=0.
REQ-020 ADDR_ACK: at the next SCL fall, release ACK; rw_flag=0 -> RX_DATA; rw_flag=1 -> load tx_data, pulse tx_load, drive bit7 (sda_oe = ~bit) and enter TX_DATA.
REQ-021 RX_DATA: after 8th rising edge update rx_data and pulse rx_valid; at following SCL fall go to RX_ACK driving sda_oe=1; next SCL fall release and return to RX_DATA.
REQ-022 TX_DATA: drive next bit each SCL fall; after bit0's fall, release SDA and enter TX_ACK.
REQ-023 TX_ACK: sample SDA at SCL rise; ACK(0) -> reload tx_data, pulse tx_load, continue TX_DATA at next fall; NACK(1) -> WAIT_STOP, sda_oe=0.
REQ-024 Bit counter 3 bits, wraps 0->7 on byte boundary; no byte limit per transaction.
REQ-025 Simultaneous SCL and SDA changes in one clk SHALL not be decoded as START/STOP.

Reset
REQ-026 rst_n low SHALL immediately force sda_oe=0, state IDLE, rx_data=8'h00, rx_valid=0, tx_load=0, busy=0, rw_flag=0, synchronizers to 1, bit counter 7.
REQ-027 After reset the block SHALL ignore the bus until a START is seen; reset mid-byte SHALL never leave SDA held low.

Structure
REQ-028 Package i2c_pkg SHALL hold the state enum (4-bit, encodings of REQ-017) and the ADDR_W=7 / BYTE_W=8 constants, shared with the master.
REQ-029 Sub-module i2c_sync_edge SHALL implement one synchronizer plus rise/fall detection, instantiated for SCL and SDA.

Verification
REQ-030 Master write addr 0x01 W, data 0xAB, STOP -> ACK on both bytes, rx_data=0xAB, exactly one rx_valid, busy low after STOP.
REQ-031 Master read addr 0x01 R, tx_data=0xC3, master NACK -> SDA bits 1,1,0,0,0,0,1,1, one tx_load, sda_oe=0 in WAIT_STOP.
REQ-032 Address 0x05 W with data 0x55 -> sda_oe never asserted, rx_valid never pulses, state IDLE after STOP.
REQ-033 Write 0x11, 0x22, then repeated START + read with tx_data 0x5A, master ACK then NACK -> two rx_valid pulses, two read bytes 0x5A, two tx_load pulses.
REQ-034 rst_n asserted during an ACK (sda_oe=1) -> sda_oe=0 within the same clk, all outputs at reset values.
REQ-035 SCL and SDA toggled in the same clk while SCL high -> no START/STOP decode, state unchanged.
